// File: rtl/slice_buffer_sched.sv
// Ping-pong slice buffer scheduler: turns the pixel stream into bank writes and
// hands completed slices to the LED readout, arbitrating bank ownership.
module slice_buffer_sched #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 24,
   parameter int SLICE_W = 7,
   parameter int DROP_W  = 8
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               flush,
   input  logic               pixel_valid,
   input  logic [DATA_W-1:0]  pixel_data,
   input  logic [2:0]         pixel_col,
   input  logic [3:0]         pixel_line,
   input  logic [2:0]         block_col,
   input  logic [1:0]         block_line,
   input  logic               eos,
   input  logic [SLICE_W-1:0] wslice_cnt,
   output logic               wr_en,
   output logic               wr_bank,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [DATA_W-1:0]  wr_data,
   input  logic               rd_req,
   output logic               rd_ack,
   output logic               rd_bank,
   output logic [SLICE_W-1:0] rd_slice,
   input  logic               rd_done,
   output logic               overrun,
   output logic [DROP_W-1:0]  drop_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FULL    = 2'd1,
      ST_READING = 2'd2
   } bank_st_t;

   bank_st_t            r_st0, r_st1;
   bank_st_t            w_st0_nxt, w_st1_nxt;
   logic                r_wb, w_wb_nxt;
   logic [SLICE_W-1:0]  r_tag0, r_tag1, w_tag0_nxt, w_tag1_nxt;
   logic                w_ack_nxt, w_ovr_nxt;
   logic                w_rd_bank_nxt;
   logic [SLICE_W-1:0]  w_rd_slice_nxt;
   logic [DROP_W-1:0]   w_drop_nxt;
   logic                w_busy;
   logic                w_other_empty;
   logic [SLICE_W-1:0]  w_slice_id;
   logic [11:0]         w_coord;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign w_coord    = {block_line, pixel_line, block_col, pixel_col};
   assign w_slice_id = wslice_cnt - 1'b1;

   // Write path: straight one-cycle pipeline, never gated by bank state.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_en   <= 1'b0;
         wr_bank <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en   <= pixel_valid;
         wr_bank <= r_wb;
         wr_addr <= ADDR_W'(w_coord);
         wr_data <= pixel_data;
      end
   end

   // Bank ownership next-state: flush, then rd_done, then grant, then eos swap.
   always_comb begin
      w_st0_nxt      = r_st0;
      w_st1_nxt      = r_st1;
      w_wb_nxt       = r_wb;
      w_tag0_nxt     = r_tag0;
      w_tag1_nxt     = r_tag1;
      w_ack_nxt      = 1'b0;
      w_ovr_nxt      = 1'b0;
      w_rd_bank_nxt  = rd_bank;
      w_rd_slice_nxt = rd_slice;
      w_drop_nxt     = drop_cnt;
      w_busy         = (r_st0 == ST_READING) || (r_st1 == ST_READING);
      w_other_empty  = 1'b0;

      if (flush) begin
         w_st0_nxt = ST_EMPTY;
         w_st1_nxt = ST_EMPTY;
         w_wb_nxt  = 1'b0;
      end else begin
         if (rd_done) begin
            if (r_st0 == ST_READING) w_st0_nxt = ST_EMPTY;
            if (r_st1 == ST_READING) w_st1_nxt = ST_EMPTY;
         end

         // At most one bank can be FULL, so the order of these tests is irrelevant.
         if (rd_req && !rd_done && !w_busy) begin
            if (r_st0 == ST_FULL) begin
               w_st0_nxt      = ST_READING;
               w_ack_nxt      = 1'b1;
               w_rd_bank_nxt  = 1'b0;
               w_rd_slice_nxt = r_tag0;
            end else if (r_st1 == ST_FULL) begin
               w_st1_nxt      = ST_READING;
               w_ack_nxt      = 1'b1;
               w_rd_bank_nxt  = 1'b1;
               w_rd_slice_nxt = r_tag1;
            end
         end

         if (eos) begin
            w_other_empty = r_wb ? (w_st0_nxt == ST_EMPTY) : (w_st1_nxt == ST_EMPTY);
            if (w_other_empty) begin
               if (r_wb) begin
                  w_st1_nxt  = ST_FULL;
                  w_tag1_nxt = w_slice_id;
               end else begin
                  w_st0_nxt  = ST_FULL;
                  w_tag0_nxt = w_slice_id;
               end
               w_wb_nxt = ~r_wb;
            end else begin
               w_ovr_nxt  = 1'b1;
               w_drop_nxt = sat_inc(drop_cnt);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_st0    <= ST_EMPTY;
         r_st1    <= ST_EMPTY;
         r_wb     <= 1'b0;
         r_tag0   <= '0;
         r_tag1   <= '0;
         rd_ack   <= 1'b0;
         rd_bank  <= 1'b0;
         rd_slice <= '0;
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         r_st0    <= w_st0_nxt;
         r_st1    <= w_st1_nxt;
         r_wb     <= w_wb_nxt;
         r_tag0   <= w_tag0_nxt;
         r_tag1   <= w_tag1_nxt;
         rd_ack   <= w_ack_nxt;
         rd_bank  <= w_rd_bank_nxt;
         rd_slice <= w_rd_slice_nxt;
         overrun  <= w_ovr_nxt;
         drop_cnt <= w_drop_nxt;
      end
   end

endmodule

// File: tb/tb_slice_buffer_sched.sv
// Bench for slice_buffer_sched: directed scenarios plus random traffic, all
// outputs compared every cycle against a bank-ownership reference model.
module tb_slice_buffer_sched;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 24;
   localparam int SLICE_W = 7;
   localparam int DROP_W  = 8;

   logic               clk = 1'b0;
   logic               nrst;
   logic               flush;
   logic               pixel_valid;
   logic [DATA_W-1:0]  pixel_data;
   logic [2:0]         pixel_col;
   logic [3:0]         pixel_line;
   logic [2:0]         block_col;
   logic [1:0]         block_line;
   logic               eos;
   logic [SLICE_W-1:0] wslice_cnt;
   logic               wr_en;
   logic               wr_bank;
   logic [ADDR_W-1:0]  wr_addr;
   logic [DATA_W-1:0]  wr_data;
   logic               rd_req;
   logic               rd_ack;
   logic               rd_bank;
   logic [SLICE_W-1:0] rd_slice;
   logic               rd_done;
   logic               overrun;
   logic [DROP_W-1:0]  drop_cnt;

   slice_buffer_sched #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLICE_W(SLICE_W), .DROP_W(DROP_W)
   ) dut (
      .clk(clk), .nrst(nrst), .flush(flush),
      .pixel_valid(pixel_valid), .pixel_data(pixel_data),
      .pixel_col(pixel_col), .pixel_line(pixel_line),
      .block_col(block_col), .block_line(block_line),
      .eos(eos), .wslice_cnt(wslice_cnt),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_ack(rd_ack), .rd_bank(rd_bank), .rd_slice(rd_slice),
      .rd_done(rd_done), .overrun(overrun), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: bank states 0=empty 1=full 2=reading.
   int m_st[2];
   int m_tag[2];
   int m_wb, m_drop;
   int e_wr_en, e_wr_bank, e_wr_addr, e_wr_data;
   int e_ack, e_rb, e_rs, e_ovr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_st[0] = 0; m_st[1] = 0; m_tag[0] = 0; m_tag[1] = 0;
      m_wb = 0; m_drop = 0;
      e_wr_en = 0; e_wr_bank = 0; e_wr_addr = 0; e_wr_data = 0;
      e_ack = 0; e_rb = 0; e_rs = 0; e_ovr = 0;
   endfunction

   function automatic void model_step();
      int n[2];
      n[0] = m_st[0]; n[1] = m_st[1];
      e_wr_en   = int'(pixel_valid);
      e_wr_bank = m_wb;
      e_wr_addr = int'({block_line, pixel_line, block_col, pixel_col});
      e_wr_data = int'(pixel_data);
      e_ack = 0;
      e_ovr = 0;
      if (flush) begin
         n[0] = 0; n[1] = 0; m_wb = 0;
      end else begin
         if (rd_done)
            for (int b = 0; b < 2; b++) if (m_st[b] == 2) n[b] = 0;
         if (rd_req && !rd_done && m_st[0] != 2 && m_st[1] != 2)
            for (int b = 0; b < 2; b++)
               if (m_st[b] == 1) begin
                  n[b] = 2; e_ack = 1; e_rb = b; e_rs = m_tag[b];
               end
         if (eos) begin
            if (n[1-m_wb] == 0) begin
               n[m_wb] = 1;
               m_tag[m_wb] = (int'(wslice_cnt) + 127) % 128;
               m_wb = 1 - m_wb;
            end else begin
               e_ovr = 1;
               if (m_drop < 255) m_drop++;
            end
         end
      end
      m_st[0] = n[0]; m_st[1] = n[1];
   endfunction

   task automatic check_outs();
      chk("wr_en",    wr_en,    e_wr_en);
      chk("wr_bank",  wr_bank,  e_wr_bank);
      chk("wr_addr",  wr_addr,  e_wr_addr);
      chk("wr_data",  wr_data,  e_wr_data);
      chk("rd_ack",   rd_ack,   e_ack);
      chk("rd_bank",  rd_bank,  e_rb);
      chk("rd_slice", rd_slice, e_rs);
      chk("overrun",  overrun,  e_ovr);
      chk("drop_cnt", drop_cnt, m_drop);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_outs();
   endtask

   task automatic clear_inputs();
      flush = 0; pixel_valid = 0; pixel_data = '0;
      pixel_col = '0; pixel_line = '0; block_col = '0; block_line = '0;
      eos = 0; rd_req = 0; rd_done = 0;
   endtask

   task automatic do_reset();
      nrst = 0;
      clear_inputs();
      wslice_cnt = '0;
      model_reset();
      #2;
      check_outs();
      @(posedge clk);
      #1;
      nrst = 1;
   endtask

   task automatic pix();
      pixel_valid = 1;
      pixel_data  = DATA_W'($urandom);
      pixel_col   = 3'($urandom);
      pixel_line  = 4'($urandom);
      block_col   = 3'($urandom);
      block_line  = 2'($urandom);
      tick();
      pixel_valid = 0;
   endtask

   task automatic send_eos();
      wslice_cnt = wslice_cnt + 1'b1;
      eos = 1;
      tick();
      eos = 0;
   endtask

   task automatic send_slice(input int n);
      repeat (n) pix();
      send_eos();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, acks;
      logic [ADDR_W-1:0] last_addr;
      logic [1:0] st0_obs, st1_obs;

      // Reset state
      do_reset();

      // 1) full 1920-pixel slice into bank0
      cnt = 0;
      last_addr = '0;
      for (int bl = 0; bl < 3; bl++)
         for (int pl = 0; pl < 16; pl++)
            for (int bc = 0; bc < 5; bc++)
               for (int pc = 0; pc < 8; pc++) begin
                  pixel_valid = 1;
                  pixel_data  = DATA_W'($urandom);
                  block_line  = 2'(bl);
                  pixel_line  = 4'(pl);
                  block_col   = 3'(bc);
                  pixel_col   = 3'(pc);
                  tick();
                  if (wr_en && !wr_bank) cnt++;
                  last_addr = wr_addr;
               end
      pixel_valid = 0;
      chk("t1_wr_count", cnt, 1920);
      chk("t1_last_addr", last_addr, {2'd2, 4'd15, 3'd4, 3'd7});
      send_eos();
      st0_obs = dut.r_st0;
      chk("t1_bank0_full", st0_obs, 2'd1);
      chk("t1_wb", dut.r_wb, 1);

      // 2) grant bank0, then release
      rd_req = 1;
      acks = 0;
      repeat (5) begin
         tick();
         if (rd_ack) begin
            acks++;
            chk("t2_rd_bank", rd_bank, 0);
            chk("t2_rd_slice", rd_slice, 0);
         end
      end
      chk("t2_ack_count", acks, 1);
      rd_done = 1;
      tick();
      rd_done = 0;
      acks = 0;
      repeat (4) begin
         tick();
         if (rd_ack) acks++;
      end
      chk("t2_no_second_ack", acks, 0);
      st0_obs = dut.r_st0;
      chk("t2_bank0_empty", st0_obs, 2'd0);
      rd_req = 0;

      // 3) slices with no reader: second and third eos overrun
      do_reset();
      send_slice(4);
      repeat (4) pix();
      send_eos();
      chk("t3_overrun", overrun, 1);
      chk("t3_drop1", drop_cnt, 1);
      chk("t3_wb", dut.r_wb, 1);
      tick();
      chk("t3_overrun_pulse", overrun, 0);
      send_slice(3);
      chk("t3_drop2", drop_cnt, 2);

      // 4) rd_done coincident with eos
      do_reset();
      send_slice(3);
      rd_req = 1;
      tick();
      chk("t4_grant0", rd_ack, 1);
      repeat (3) pix();
      wslice_cnt = wslice_cnt + 1'b1;
      eos = 1;
      rd_done = 1;
      tick();
      eos = 0;
      rd_done = 0;
      chk("t4_no_overrun", overrun, 0);
      chk("t4_no_ack_same", rd_ack, 0);
      chk("t4_wb", dut.r_wb, 0);
      tick();
      chk("t4_ack", rd_ack, 1);
      chk("t4_rd_bank", rd_bank, 1);
      chk("t4_rd_slice", rd_slice, 1);
      rd_req = 0;

      // 5) mid-slice flush with bank0 full
      do_reset();
      send_slice(2);
      repeat (3) pix();
      flush = 1;
      tick();
      flush = 0;
      st0_obs = dut.r_st0;
      st1_obs = dut.r_st1;
      chk("t5_st0", st0_obs, 2'd0);
      chk("t5_st1", st1_obs, 2'd0);
      chk("t5_wb", dut.r_wb, 0);
      rd_req = 1;
      acks = 0;
      repeat (5) begin
         tick();
         if (rd_ack) acks++;
      end
      chk("t5_no_ack", acks, 0);
      send_slice(2);
      repeat (3) begin
         tick();
         if (rd_ack) acks++;
      end
      chk("t5_ack_after_eos", acks, 1);
      rd_req = 0;

      // 6) saturation, async reset mid-slice, slice index wrap
      do_reset();
      send_slice(1);
      repeat (300) begin
         pix();
         send_eos();
      end
      chk("t6_drop_sat", drop_cnt, 8'hFF);
      repeat (5) pix();
      do_reset();
      wslice_cnt = 7'h7F;
      send_eos();
      rd_req = 1;
      tick();
      chk("t6_wrap_ack", rd_ack, 1);
      chk("t6_wrap_slice", rd_slice, 7'h7F);
      rd_req = 0;

      // Random traffic
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset();
         pixel_valid = 1'($urandom);
         pixel_data  = DATA_W'($urandom);
         pixel_col   = 3'($urandom);
         pixel_line  = 4'($urandom);
         block_col   = 3'($urandom);
         block_line  = 2'($urandom);
         eos = ($urandom_range(0, 15) == 0);
         if (eos) wslice_cnt = wslice_cnt + 1'b1;
         if ($urandom_range(0, 7) == 0) rd_req = ~rd_req;
         rd_done = ($urandom_range(0, 9) == 0);
         flush   = ($urandom_range(0, 199) == 0);
         tick();
      end
      clear_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
